mult_sequencer: RTL and testbench

Cycle-level controller for the 8-bit add-shift signed multiplier datapath: register unit with X:A:B, 9-bit adder/subtractor, synchronized switch input. It turns a load request and an execute request into the exact sequence of Clear/Load/Shift/Subtract strobes for one multiply. It presents a Busy/Done handshake to the top level. It sits between the input synchronizers and the register unit/adder, and takes the place of ad-hoc control there.

---
 rtl/mult_sequencer_if.sv | 26 ++
 rtl/mult_sequencer.sv | 127 ++++++++++++
 tb/tb_mult_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// Handshake and strobe bundle between the multiply sequencer and the
// logic around it (input synchronizers, register unit, adder).
// The master side issues requests and supplies the multiplier bit; the
// slave side (the sequencer) drives the datapath strobes and status.
interface mult_sequencer_if;
    logic Load_Req;
    logic Start;
    logic M;
    logic Clear_XA;
    logic Ld_B;
    logic Ld_XA;
    logic Shift_En;
    logic Subtract;
    logic Busy;
    logic Done;

    modport master (
        output Load_Req, Start, M,
        input  Clear_XA, Ld_B, Ld_XA, Shift_En, Subtract, Busy, Done
    );

    modport slave (
        input  Load_Req, Start, M,
        output Clear_XA, Ld_B, Ld_XA, Shift_En, Subtract, Busy, Done
    );
endinterface

// File: rtl/mult_sequencer.sv
// Control sequencer for the add-shift signed multiplier datapath (X:A:B
// register unit plus 9-bit adder/subtractor). A load request loads B and
// clears X:A; a rising edge on Start runs N_BITS add/shift iterations with
// a fixed latency, the last add becoming a subtract when the multiplier
// sign bit is set. Done is held until Start is released.
module mult_sequencer #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = $clog2(N_BITS)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mult_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              start_q;
    logic              start_edge;
    logic              last_iter;

    logic clear_xa;
    logic ld_b;
    logic ld_xa;
    logic shift_en;
    logic subtract;
    logic busy;
    logic done;

    // start_q resets high so a Start held through reset release is not an edge.
    assign start_edge = bus.Start & ~start_q;
    assign last_iter  = (cnt_reg == LAST_CNT);

    // State, iteration counter and Start history register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            start_q   <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            start_q   <= bus.Start;
        end
    end

    // Next-state and strobe decode; Ld_XA/Subtract follow the live multiplier bit.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clear_xa   = 1'b0;
        ld_b       = 1'b0;
        ld_xa      = 1'b0;
        shift_en   = 1'b0;
        subtract   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Load has priority; a coincident Start edge is dropped.
                if (bus.Load_Req) begin
                    state_next = LOAD;
                end else if (start_edge) begin
                    state_next = CLEAR;
                end
            end
            LOAD: begin
                ld_b       = 1'b1;
                clear_xa   = 1'b1;
                state_next = IDLE;
            end
            CLEAR: begin
                clear_xa   = 1'b1;
                busy       = 1'b1;
                cnt_next   = '0;
                state_next = ADD;
            end
            ADD: begin
                busy       = 1'b1;
                ld_xa      = bus.M;
                // Multiplier sign bit carries negative weight: subtract on the last step.
                subtract   = bus.M & last_iter;
                state_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = ADD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!bus.Start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Clear_XA = clear_xa;
    assign bus.Ld_B     = ld_b;
    assign bus.Ld_XA    = ld_xa;
    assign bus.Shift_En = shift_en;
    assign bus.Subtract = subtract;
    assign bus.Busy     = busy;
    assign bus.Done     = done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: drives load/start requests around a behavioural
// X:A:B datapath, queues hand-computed expected transactions, and a monitor
// pops and compares them when the sequencer produces a load or a Done.
module tb_mult_sequencer;

    localparam int N_BITS = 8;
    localparam logic K_LOAD = 1'b0;
    localparam logic K_MULT = 1'b1;

    typedef struct {
        logic        kind;
        logic [7:0]  ld_mask;
        logic [7:0]  sub_mask;
        logic [15:0] prod;
        logic        x;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [7:0] sw;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       x_reg;
    logic [8:0] sum;

    int checks;
    int errors;
    exp_t q[$];

    mult_sequencer_if bus();

    mult_sequencer #(.N_BITS(N_BITS)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register unit and adder driven by the strobes.
    assign bus.M = b_reg[0];
    assign sum = bus.Subtract ? ({a_reg[7], a_reg} - {sw[7], sw})
                              : ({a_reg[7], a_reg} + {sw[7], sw});

    always @(posedge clk) begin
        if (bus.Clear_XA) begin
            x_reg <= 1'b0;
            a_reg <= 8'h00;
        end
        if (bus.Ld_B) b_reg <= sw;
        if (bus.Ld_XA) {x_reg, a_reg} <= sum;
        if (bus.Shift_En) begin
            a_reg <= {x_reg, a_reg[7:1]};
            b_reg <= {a_reg[0], b_reg[7:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_load();
        exp_t e;
        e.kind = K_LOAD; e.ld_mask = 8'h00; e.sub_mask = 8'h00; e.prod = 16'h0; e.x = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_mult(input logic [7:0] ldm, input logic [7:0] subm,
                             input logic [15:0] prod, input logic x);
        exp_t e;
        e.kind = K_MULT; e.ld_mask = ldm; e.sub_mask = subm; e.prod = prod; e.x = x;
        q.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.Done && n < 60) begin
            tick(1);
            n++;
        end
        if (!bus.Done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got Done=0 expected Done=1 within 60 cycles");
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {25'd0, bus.Clear_XA, bus.Ld_B, bus.Ld_XA, bus.Shift_En,
                   bus.Subtract, bus.Busy, bus.Done}, 32'd0);
    endtask

    // Monitor: tracks one multiply at a time and scores loads and completions.
    int         cyc;
    int         start_rise_cyc;
    int         clear_cyc;
    int         busy_cnt;
    int         shifts;
    logic       in_mult;
    logic       start_prev;
    logic       done_prev;
    logic [7:0] ldm;
    logic [7:0] subm;
    exp_t       e_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_mult    = 1'b0;
            start_prev = 1'b1;
            done_prev  = 1'b0;
        end else begin
            cyc++;
            if (bus.Start && !start_prev) start_rise_cyc = cyc;
            start_prev = bus.Start;

            chk("strobe_exclusive",
                {31'd0, ((32'(bus.Clear_XA) + 32'(bus.Ld_XA) + 32'(bus.Shift_En)) > 1)
                        || (bus.Subtract && !bus.Ld_XA)}, 32'd0);

            if (bus.Ld_B) begin
                if (q.size() == 0 || q[0].kind != K_LOAD) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: got Ld_B=1 at cycle %0d expected none", cyc);
                end else begin
                    e_m = q.pop_front();
                    chk("load_strobes", {30'd0, bus.Clear_XA, bus.Busy}, 32'h2);
                    $display("load at cycle %0d", cyc);
                end
            end

            if (bus.Clear_XA && bus.Busy) begin
                if (q.size() == 0 || q[0].kind != K_MULT || in_mult) begin
                    checks++; errors++;
                    $display("FAIL unexpected_clear: got CLEAR at cycle %0d expected none", cyc);
                end
                chk("start_to_clear", 32'(cyc - start_rise_cyc), 32'd1);
                in_mult   = 1'b1;
                clear_cyc = cyc;
                busy_cnt  = 0;
                shifts    = 0;
                ldm       = 8'h00;
                subm      = 8'h00;
            end

            if (in_mult) begin
                if (bus.Busy) busy_cnt++;
                if (bus.Busy && !bus.Clear_XA && !bus.Shift_En && shifts < N_BITS) begin
                    ldm[shifts[2:0]]  = bus.Ld_XA;
                    subm[shifts[2:0]] = bus.Subtract;
                end
                if (bus.Shift_En) shifts++;
            end

            if (bus.Done && !done_prev) begin
                if (!in_mult || q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got Done at cycle %0d expected none", cyc);
                end else begin
                    e_m = q.pop_front();
                    chk("mult_kind", {31'd0, e_m.kind}, {31'd0, K_MULT});
                    chk("clear_to_done", 32'(cyc - clear_cyc), 32'(2 * N_BITS + 1));
                    chk("busy_cycles", 32'(busy_cnt), 32'(2 * N_BITS + 1));
                    chk("shift_count", 32'(shifts), 32'(N_BITS));
                    chk("ld_xa_mask", {24'd0, ldm}, {24'd0, e_m.ld_mask});
                    chk("subtract_mask", {24'd0, subm}, {24'd0, e_m.sub_mask});
                    chk("product_ab", {16'd0, a_reg, b_reg}, {16'd0, e_m.prod});
                    chk("x_bit", {31'd0, x_reg}, {31'd0, e_m.x});
                    $display("mult done at cycle %0d product=0x%04h x=%0b", cyc, {a_reg, b_reg}, x_reg);
                end
                in_mult = 1'b0;
            end
            done_prev = bus.Done;
        end
    end

    // Directed stimulus.
    initial begin
        checks = 0; errors = 0; cyc = 0; start_rise_cyc = 0; clear_cyc = 0;
        busy_cnt = 0; shifts = 0; ldm = 8'h00; subm = 8'h00;
        rst_n = 1'b0; bus.Load_Req = 1'b0; bus.Start = 1'b0; sw = 8'h00;
        #1;
        check_outputs_zero("reset_outputs");
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_outputs_zero("idle_after_reset");

        // 7 x -3 = -21
        sw = 8'h07; push_load(); bus.Load_Req = 1'b1; tick(1); bus.Load_Req = 1'b0; tick(2);
        sw = 8'hFD; push_mult(8'h07, 8'h00, 16'hFFEB, 1'b1);
        bus.Start = 1'b1; wait_done(); bus.Start = 1'b0; tick(2);

        // -128 x -128 = 16384, with a Load_Req pulse while busy that must be ignored
        sw = 8'h80; push_load(); bus.Load_Req = 1'b1; tick(1); bus.Load_Req = 1'b0; tick(2);
        push_mult(8'h80, 8'h80, 16'h4000, 1'b0);
        bus.Start = 1'b1; tick(5);
        bus.Load_Req = 1'b1; tick(2); bus.Load_Req = 1'b0;
        wait_done(); bus.Start = 1'b0; tick(2);

        // B=0xFD (-3) x 5 = -15, Start held 40 cycles: one multiply only
        sw = 8'hFD; push_load(); bus.Load_Req = 1'b1; tick(1); bus.Load_Req = 1'b0; tick(2);
        sw = 8'h05; push_mult(8'hFD, 8'h80, 16'hFFF1, 1'b1);
        bus.Start = 1'b1; tick(40);
        chk("done_held", {31'd0, bus.Done}, 32'd1);
        bus.Start = 1'b0; tick(2);
        chk("idle_after_release", {30'd0, bus.Busy, bus.Done}, 32'd0);

        // Re-press: 5 x 3 = 15
        sw = 8'h05; push_load(); bus.Load_Req = 1'b1; tick(1); bus.Load_Req = 1'b0; tick(2);
        sw = 8'h03; push_mult(8'h05, 8'h00, 16'h000F, 1'b0);
        bus.Start = 1'b1; wait_done(); bus.Start = 1'b0; tick(2);

        // Simultaneous Load_Req and Start edge: load only
        sw = 8'h11; push_load();
        bus.Load_Req = 1'b1; bus.Start = 1'b1; tick(1); bus.Load_Req = 1'b0;
        tick(5);
        chk("no_busy_on_collision", {31'd0, bus.Busy}, 32'd0);
        bus.Start = 1'b0; tick(2);

        // Reset mid-ADD with Start held, then release with Start still high
        sw = 8'h07; push_load(); bus.Load_Req = 1'b1; tick(1); bus.Load_Req = 1'b0; tick(2);
        sw = 8'h03; push_mult(8'h07, 8'h00, 16'h0015, 1'b0);
        bus.Start = 1'b1; tick(4);
        chk("in_add_before_reset", {29'd0, bus.Busy, bus.Clear_XA, bus.Shift_En}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset_outputs");
        q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("no_start_after_reset", {30'd0, bus.Busy, bus.Done}, 32'd0);
        bus.Start = 1'b0; tick(2);

        // -2 x 9 = -18 after reset recovery
        sw = 8'hFE; push_load(); bus.Load_Req = 1'b1; tick(1); bus.Load_Req = 1'b0; tick(2);
        sw = 8'h09; push_mult(8'hFE, 8'h80, 16'hFFEE, 1'b1);
        bus.Start = 1'b1; wait_done(); bus.Start = 1'b0; tick(3);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
